audio_track_sequencer: RTL

- Scheduler that shares one 8 kHz sample-playback path (sample ROMs feeding the PWM audio engine) among three requesters:
  - initial-page BGM
  - fight-page BGM
  - one-shot sound effect (SFX)
- Generates the sample-rate tick, owns the ROM address counter and selects the active ROM.
- A sound effect pre-empts BGM; playback returns to BGM when the effect finishes.
- Inserts a short muted gap on BGM track changes to avoid clicks.

---
 rtl/audio_track_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/audio_track_sequencer.sv
// audio_track_sequencer: shares one sample-playback path between two looping
// BGM tracks and a one-shot sound effect. Generates the sample tick, owns the
// ROM address counter and selects the active ROM.
// Optional feature macro: AUDIO_SEQ_BGM_RESUME_EN (resume BGM at the saved
// address after an effect instead of restarting it).
module audio_track_sequencer #(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int SAMPLE_RATE_HZ   = 8000,
    parameter int ADDR_W           = 15,
    parameter int BGM0_LEN         = 22400,
    parameter int BGM1_LEN         = 22400,
    parameter int SFX_LEN          = 4000,
    parameter int MUTE_TICKS       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        bgm_sel,
    input  logic              sfx_req,
    output logic              sample_tick,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        rom_sel,
    output logic              rom_ce,
    output logic              aud_en,
    output logic              sfx_busy,
    output logic              sfx_done
);

    localparam int DIV   = CLK_FREQUENCY_HZ / SAMPLE_RATE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = (MUTE_TICKS > 1) ? $clog2(MUTE_TICKS) : 1;

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MUTE_TICKS - 1);
    localparam logic [ADDR_W-1:0] BGM0_LAST = ADDR_W'(BGM0_LEN - 1);
    localparam logic [ADDR_W-1:0] BGM1_LAST = ADDR_W'(BGM1_LEN - 1);
    localparam logic [ADDR_W-1:0] SFX_LAST  = ADDR_W'(SFX_LEN - 1);

    localparam logic [1:0] SEL_BGM0 = 2'd0;
    localparam logic [1:0] SEL_BGM1 = 2'd1;
    localparam logic [1:0] SEL_SFX  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        PLAY_BGM,
        GAP,
        PLAY_SFX
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  div_cnt_n;
    logic              tick_n;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_n;
    logic [ADDR_W-1:0] addr_n;
    logic [1:0]        sel_n;
    logic              done_n;
    logic              bgm_valid;
    logic [1:0]        bgm_track;
    logic [ADDR_W-1:0] bgm_last;

    // Decode the BGM request and the loop end of the track currently playing
    always_comb begin
        bgm_valid = (bgm_sel == 2'b01) || (bgm_sel == 2'b10);
        bgm_track = (bgm_sel == 2'b10) ? SEL_BGM1 : SEL_BGM0;
        bgm_last  = (rom_sel == SEL_BGM1) ? BGM1_LAST : BGM0_LAST;
    end

    // Look ahead one cycle on the divider so sample_tick can be a register
    always_comb begin
        div_cnt_n = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        tick_n    = (div_cnt_n == DIV_LAST);
    end

`ifdef AUDIO_SEQ_BGM_RESUME_EN
    logic [ADDR_W-1:0] saved_addr;
    logic [1:0]        saved_sel;
    logic              saved_valid;

    // Capture the interrupted BGM position when an effect takes over the path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            saved_addr  <= '0;
            saved_sel   <= SEL_BGM0;
            saved_valid <= 1'b0;
        end else if (state != PLAY_SFX && state_n == PLAY_SFX) begin
            saved_addr  <= rom_addr;
            saved_sel   <= rom_sel;
            saved_valid <= (state == PLAY_BGM);
        end
    end
`endif

    // Next-state, next-address and next-select decisions for the scheduler
    always_comb begin
        state_n = state;
        addr_n  = rom_addr;
        sel_n   = rom_sel;
        gap_n   = gap_cnt;
        if (sfx_req && state != PLAY_SFX) begin
            state_n = PLAY_SFX;
            addr_n  = '0;
            sel_n   = SEL_SFX;
        end else begin
            case (state)
                IDLE: begin
                    if (bgm_valid) begin
                        state_n = PLAY_BGM;
                        addr_n  = '0;
                        sel_n   = bgm_track;
                    end
                end
                PLAY_BGM: begin
                    if (!bgm_valid) begin
                        state_n = IDLE;
                        addr_n  = '0;
                    end else if (bgm_track != rom_sel) begin
                        state_n = GAP;
                        gap_n   = '0;
                    end else if (sample_tick) begin
                        addr_n = (rom_addr == bgm_last) ? '0 : rom_addr + 1'b1;
                    end
                end
                GAP: begin
                    if (sample_tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            addr_n = '0;
                            if (bgm_valid) begin
                                state_n = PLAY_BGM;
                                sel_n   = bgm_track;
                            end else begin
                                state_n = IDLE;
                            end
                        end else begin
                            gap_n = gap_cnt + 1'b1;
                        end
                    end
                end
                PLAY_SFX: begin
                    if (sample_tick) begin
                        if (rom_addr == SFX_LAST) begin
                            if (bgm_valid) begin
                                state_n = PLAY_BGM;
                                sel_n   = bgm_track;
`ifdef AUDIO_SEQ_BGM_RESUME_EN
                                addr_n  = (saved_valid && saved_sel == bgm_track) ? saved_addr : '0;
`else
                                addr_n  = '0;
`endif
                            end else begin
                                state_n = IDLE;
                                sel_n   = SEL_BGM0;
                                addr_n  = '0;
                            end
                        end else begin
                            addr_n = rom_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    addr_n  = '0;
                    sel_n   = SEL_BGM0;
                end
            endcase
        end
        done_n = (state_n == PLAY_SFX) && (addr_n == SFX_LAST) && tick_n;
    end

    // Register state, divider and every output so nothing glitches downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            gap_cnt     <= '0;
            sample_tick <= 1'b0;
            rom_addr    <= '0;
            rom_sel     <= SEL_BGM0;
            rom_ce      <= 1'b0;
            aud_en      <= 1'b0;
            sfx_busy    <= 1'b0;
            sfx_done    <= 1'b0;
        end else begin
            state       <= state_n;
            div_cnt     <= div_cnt_n;
            gap_cnt     <= gap_n;
            sample_tick <= tick_n;
            rom_addr    <= addr_n;
            rom_sel     <= sel_n;
            rom_ce      <= (state_n == PLAY_BGM) || (state_n == PLAY_SFX);
            aud_en      <= (state_n == PLAY_BGM) || (state_n == PLAY_SFX);
            sfx_busy    <= (state_n == PLAY_SFX);
            sfx_done    <= done_n;
        end
    end

endmodule
